imem_boot_loader: RTL and testbench

//  Upstream of the 5-stage core: receives a program as a byte stream, packs it into
//  32-bit words and writes them to instruction memory from word address 0.

---
 rtl/imem_boot_loader.sv | 150 +++++++++++++++
 tb/tb_imem_boot_loader.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: takes a little-endian word count N followed by N words,
// writes them to instruction memory from address 0, then releases the core reset.
// Optional trailing XOR checksum byte when BOOT_CHECKSUM_EN is defined.
module imem_boot_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              boot_done,
    output logic              boot_err,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        HDR,
        LOAD,
`ifdef BOOT_CHECKSUM_EN
        CHK,
`endif
        DONE,
        ERR
    } state_t;

    localparam logic [32:0] CAPACITY = 33'd1 << ADDR_W;

    state_t          stateReg;
    state_t          stateNext;
    logic [1:0]      byteCntReg;
    logic [23:0]     shiftReg;
    logic [ADDR_W:0] nReg;
    logic [ADDR_W:0] wordsInc;
    logic [31:0]     assembled;
    logic            accepting;
    logic            xfer;
    logic            lastByte;
    logic            hdrTooBig;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]      csumReg;
`endif

    // Earlier bytes sit in shiftReg, so the incoming byte always lands in lane 3.
    assign assembled = {byte_data, shiftReg};
    assign hdrTooBig = {1'b0, assembled} > CAPACITY;
    assign wordsInc  = words_loaded + {{ADDR_W{1'b0}}, 1'b1};

`ifdef BOOT_CHECKSUM_EN
    assign accepting = (stateReg == HDR) || (stateReg == LOAD) || (stateReg == CHK);
`else
    assign accepting = (stateReg == HDR) || (stateReg == LOAD);
`endif
    assign byte_ready = rst && accepting;
    assign xfer       = byte_valid && byte_ready;
    assign lastByte   = xfer && (byteCntReg == 2'd3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg <= HDR;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            HDR: begin
                if (lastByte) begin
                    if (assembled == 32'd0) begin
`ifdef BOOT_CHECKSUM_EN
                        stateNext = CHK;
`else
                        stateNext = DONE;
`endif
                    end else if (hdrTooBig) begin
                        stateNext = ERR;
                    end else begin
                        stateNext = LOAD;
                    end
                end
            end
            LOAD: begin
                if (lastByte && (wordsInc == nReg)) begin
`ifdef BOOT_CHECKSUM_EN
                    stateNext = CHK;
`else
                    stateNext = DONE;
`endif
                end
            end
`ifdef BOOT_CHECKSUM_EN
            CHK: begin
                if (xfer) begin
                    stateNext = (byte_data == csumReg) ? DONE : ERR;
                end
            end
`endif
            default: stateNext = stateReg;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byteCntReg   <= 2'd0;
            shiftReg     <= 24'd0;
            nReg         <= '0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= 32'd0;
            words_loaded <= '0;
            boot_done    <= 1'b0;
            boot_err     <= 1'b0;
            core_rst     <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            csumReg      <= 8'd0;
`endif
        end else begin
            imem_we   <= 1'b0;
            boot_done <= (stateNext == DONE);
            boot_err  <= (stateNext == ERR);
            // Delayed one cycle so the final write commits before the core starts fetching.
            core_rst  <= boot_done;
            if (xfer && ((stateReg == HDR) || (stateReg == LOAD))) begin
                byteCntReg <= byteCntReg + 2'd1;
                shiftReg   <= {byte_data, shiftReg[23:8]};
            end
            if (lastByte && (stateReg == HDR)) begin
                nReg <= assembled[ADDR_W:0];
            end
            if (lastByte && (stateReg == LOAD)) begin
                imem_we      <= 1'b1;
                imem_addr    <= words_loaded[ADDR_W-1:0];
                imem_wdata   <= assembled;
                words_loaded <= wordsInc;
            end
`ifdef BOOT_CHECKSUM_EN
            if (xfer && (stateReg == LOAD)) begin
                csumReg <= csumReg ^ byte_data;
            end
`endif
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected writes are queued as image bytes are
// driven and popped by a write monitor; scenario tasks check status outputs inline.
module tb_imem_boot_loader;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = 8'd0;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rst;
    logic              boot_done;
    logic              boot_err;
    logic [ADDR_W:0]   words_loaded;

    int checks = 0;
    int failures = 0;
    logic [ADDR_W+31:0] expQ[$];
    logic [ADDR_W+31:0] expWr;
    logic [31:0]        imgWords[$];

    imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk),
        .rst(rst),
        .byte_valid(byte_valid),
        .byte_data(byte_data),
        .byte_ready(byte_ready),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .core_rst(core_rst),
        .boot_done(boot_done),
        .boot_err(boot_err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Write monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            checks++;
            if (expQ.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write actual=addr %0d data %08h required=no write", imem_addr, imem_wdata);
            end else begin
                expWr = expQ.pop_front();
                if ({imem_addr, imem_wdata} !== expWr) begin
                    failures++;
                    $display("FAIL write actual=addr %0d data %08h required=addr %0d data %08h",
                             imem_addr, imem_wdata, expWr[ADDR_W+31:32], expWr[31:0]);
                end else begin
                    $display("write addr=%0d data=%08h", imem_addr, imem_wdata);
                end
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        byte_valid = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        expQ.delete();
        rst = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int guard;
        if (gap) begin
            @(negedge clk);
            byte_valid = 1'b0;
            byte_data  = 8'($urandom);
        end
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        guard = 0;
        while (byte_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) begin
            checks++;
            failures++;
            $display("FAIL byte_accept actual=byte_ready low required=accept byte %02h", b);
            byte_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            byte_valid = 1'b0;
        end
    endtask

    // Sends header and payload from imgWords; stopAfter>=0 truncates the payload.
    task automatic send_image(input logic [31:0] n, input bit gaps, input logic [7:0] csumFlip, input int stopAfter);
        logic [7:0]  c;
        logic [31:0] w;
        int sent;
        c = 8'd0;
        sent = 0;
        for (int k = 0; k < 4; k++) send_byte(n[8*k +: 8], gaps);
        for (int i = 0; i < int'(n); i++) begin
            w = imgWords[i];
            for (int k = 0; k < 4; k++) begin
                if (stopAfter >= 0 && sent == stopAfter) begin
                    $display("image n=%0d truncated after %0d payload bytes", n, sent);
                    return;
                end
                if (k == 3) expQ.push_back({ADDR_W'(i), w});
                send_byte(w[8*k +: 8], gaps);
                c = c ^ w[8*k +: 8];
                sent++;
            end
        end
        $display("image n=%0d payload_xor=%02h trailer=%02h", n, c, c ^ csumFlip);
`ifdef BOOT_CHECKSUM_EN
        send_byte(c ^ csumFlip, gaps);
`endif
    endtask

    task automatic test_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        byte_valid = 1'b1;
        #1;
        checks++;
        if (byte_ready !== 1'b0) begin failures++; $display("FAIL reset_ready actual=%b required=0", byte_ready); end
        checks++;
        if ({boot_done, boot_err, core_rst, imem_we} !== 4'b0) begin
            failures++; $display("FAIL reset_flags actual=%b required=0000", {boot_done, boot_err, core_rst, imem_we});
        end
        repeat (2) @(negedge clk);
        checks++;
        if (words_loaded !== '0) begin failures++; $display("FAIL reset_words actual=%0d required=0", words_loaded); end
        checks++;
        if (imem_addr !== '0 || imem_wdata !== 32'd0) begin
            failures++; $display("FAIL reset_addr_data actual=%0d/%08h required=0/00000000", imem_addr, imem_wdata);
        end
        byte_valid = 1'b0;
        expQ.delete();
        rst = 1'b1;
    endtask

    task automatic test_basic(input bit gaps);
        apply_reset();
        imgWords = '{32'h00000013, 32'h00100093};
        send_image(32'd2, gaps, 8'h00, -1);
        checks++;
        if (boot_done !== 1'b1) begin failures++; $display("FAIL basic_done actual=%b required=1", boot_done); end
        checks++;
        if (core_rst !== 1'b0) begin failures++; $display("FAIL basic_core_rst_early actual=%b required=0", core_rst); end
        checks++;
        if (words_loaded !== 11'd2) begin failures++; $display("FAIL basic_words actual=%0d required=2", words_loaded); end
        @(posedge clk);
        #1;
        checks++;
        if (core_rst !== 1'b1) begin failures++; $display("FAIL basic_core_rst actual=%b required=1", core_rst); end
        checks++;
        if (byte_ready !== 1'b0) begin failures++; $display("FAIL basic_ready_after_done actual=%b required=0", byte_ready); end
        checks++;
        if (expQ.size() != 0 || boot_err !== 1'b0) begin
            failures++; $display("FAIL basic_pending actual=%0d writes err=%b required=0 writes err=0", expQ.size(), boot_err);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] hdr;
        apply_reset();
        hdr = 32'h00000401;
        for (int k = 0; k < 4; k++) send_byte(hdr[8*k +: 8], 1'b0);
        $display("header n=%0d sent", hdr);
        checks++;
        if (boot_err !== 1'b1) begin failures++; $display("FAIL ovf_err actual=%b required=1", boot_err); end
        checks++;
        if (byte_ready !== 1'b0) begin failures++; $display("FAIL ovf_ready actual=%b required=0", byte_ready); end
        @(negedge clk);
        byte_valid = 1'b1;
        repeat (5) @(negedge clk);
        byte_valid = 1'b0;
        checks++;
        if (core_rst !== 1'b0 || boot_done !== 1'b0) begin
            failures++; $display("FAIL ovf_core actual=core_rst %b done %b required=0 0", core_rst, boot_done);
        end
        checks++;
        if (words_loaded !== '0 || boot_err !== 1'b1) begin
            failures++; $display("FAIL ovf_sticky actual=words %0d err %b required=0 1", words_loaded, boot_err);
        end
    endtask

    task automatic test_reset_mid_load();
        apply_reset();
        imgWords = '{32'h00000013, 32'h00100093};
        send_image(32'd2, 1'b0, 8'h00, 6);
        @(negedge clk);
        checks++;
        if (expQ.size() != 0 || words_loaded !== 11'd1) begin
            failures++; $display("FAIL mid_first_word actual=%0d pending words %0d required=0 pending words 1", expQ.size(), words_loaded);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (words_loaded !== '0 || core_rst !== 1'b0 || boot_done !== 1'b0) begin
            failures++; $display("FAIL mid_reset actual=words %0d core_rst %b done %b required=0 0 0", words_loaded, core_rst, boot_done);
        end
        @(negedge clk);
        rst = 1'b1;
        send_image(32'd2, 1'b0, 8'h00, -1);
        @(posedge clk);
        #1;
        checks++;
        if (boot_done !== 1'b1 || core_rst !== 1'b1 || words_loaded !== 11'd2) begin
            failures++; $display("FAIL mid_final actual=done %b core_rst %b words %0d required=1 1 2", boot_done, core_rst, words_loaded);
        end
        checks++;
        if (expQ.size() != 0) begin failures++; $display("FAIL mid_pending actual=%0d required=0", expQ.size()); end
    endtask

    task automatic test_empty();
        apply_reset();
        imgWords.delete();
        send_image(32'd0, 1'b0, 8'h00, -1);
        checks++;
        if (boot_done !== 1'b1 || imem_we !== 1'b0) begin
            failures++; $display("FAIL empty_done actual=done %b we %b required=1 0", boot_done, imem_we);
        end
        @(posedge clk);
        #1;
        checks++;
        if (core_rst !== 1'b1 || words_loaded !== '0) begin
            failures++; $display("FAIL empty_final actual=core_rst %b words %0d required=1 0", core_rst, words_loaded);
        end
    endtask

    task automatic test_full();
        apply_reset();
        imgWords.delete();
        for (int i = 0; i < (1 << ADDR_W); i++) imgWords.push_back($urandom);
        send_image(32'(1 << ADDR_W), 1'b0, 8'h00, -1);
        @(posedge clk);
        #1;
        checks++;
        if (words_loaded !== 11'h400) begin failures++; $display("FAIL full_words actual=%0d required=1024", words_loaded); end
        checks++;
        if (imem_addr !== 10'h3FF) begin failures++; $display("FAIL full_last_addr actual=%0h required=3ff", imem_addr); end
        checks++;
        if (boot_done !== 1'b1 || boot_err !== 1'b0 || core_rst !== 1'b1) begin
            failures++; $display("FAIL full_status actual=done %b err %b core_rst %b required=1 0 1", boot_done, boot_err, core_rst);
        end
        checks++;
        if (expQ.size() != 0) begin failures++; $display("FAIL full_pending actual=%0d required=0", expQ.size()); end
    endtask

`ifdef BOOT_CHECKSUM_EN
    task automatic test_checksum_bad();
        apply_reset();
        imgWords = '{32'h00000013, 32'h00100093};
        send_image(32'd2, 1'b0, 8'h01, -1);
        @(posedge clk);
        #1;
        checks++;
        if (boot_err !== 1'b1 || boot_done !== 1'b0 || core_rst !== 1'b0) begin
            failures++; $display("FAIL csum_bad actual=err %b done %b core_rst %b required=1 0 0", boot_err, boot_done, core_rst);
        end
        checks++;
        if (expQ.size() != 0 || words_loaded !== 11'd2) begin
            failures++; $display("FAIL csum_writes actual=%0d pending words %0d required=0 pending words 2", expQ.size(), words_loaded);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic(1'b0);
        test_reset();
        test_basic(1'b1);
        test_overflow();
        test_reset_mid_load();
        test_empty();
        test_full();
`ifdef BOOT_CHECKSUM_EN
        test_checksum_bad();
`endif
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
